// File: rtl/aes_enc_iter_umsk.sv
// -----------------------------------------------------------------------------
// aes_enc_iter_umsk -- iterative, unmasked AES-128 encryption core.
//
// One AES round per clock through a single round datapath. A separate
// final-round path (SubBytes + ShiftRows, no MixColumns) plus the last key
// addition produces the ciphertext. This core is the functional golden model
// and throughput baseline for the masked cores.
//
// Ports (all bit vectors use FIPS-197 byte order, first byte at [127:120]):
//   clk        in   1    system clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    plaintext/key offered
//   in_ready   out  1    core idle and able to accept a block
//   pt_in      in   128  plaintext
//   key_in     in   128  cipher key
//   out_valid  out  1    ciphertext available
//   out_ready  in   1    consumer accepts ciphertext
//   ct_out     out  128  ciphertext, held stable while out_valid && !out_ready
//   blk_cnt    out  32   completed output handshakes (only with AES_BLK_CNT_EN)
//
// Parameter ZEROIZE: 1 clears state/key registers on the output handshake.
// Optional macro AES_BLK_CNT_EN adds the blk_cnt port and counter.
// -----------------------------------------------------------------------------

package aes_umsk_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column, a0 in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
endpackage

// AES S-box, table form (functionally identical to the Boyar-Peralta netlist).
module sbox_bp_umsk (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  localparam logic [2047:0] SBOX_TABLE = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16};

  // Entry 0 sits in the top byte of the table.
  assign o_s = SBOX_TABLE[11'd2047 - {i_a, 3'b000} -: 8];
endmodule

// ShiftRows: byte (row r, column c) takes input byte (r, (c + r) mod 4).
module sr_umsk (
  input  logic [127:0] i_s,
  output logic [127:0] o_s
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign o_s[127 - 8*(4*c + r) -: 8] = i_s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    end
  end
endmodule

// Full round: MC(SR(SB(state ^ key))), plus next round key from key and rcon.
module aes_round_umsk (
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_state,
  output logic [127:0] o_next_key
);
  import aes_umsk_pkg::*;

  logic [127:0] w_ark, w_sb, w_sr;
  logic [31:0]  w_rot, w_sub, w_t, w_k0, w_k1, w_k2, w_k3;

  assign w_ark = i_state ^ i_key;

  for (genvar i = 0; i < 16; i++) begin : g_sb
    sbox_bp_umsk u_sb (.i_a(w_ark[8*i +: 8]), .o_s(w_sb[8*i +: 8]));
  end

  sr_umsk u_sr (.i_s(w_sb), .o_s(w_sr));

  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign o_state[32*c +: 32] = mix_col(w_sr[32*c +: 32]);
  end

  // Key schedule: RotWord, SubWord, RCON on the last word of the current key.
  assign w_rot = {i_key[23:0], i_key[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_ks
    sbox_bp_umsk u_sb (.i_a(w_rot[8*i +: 8]), .o_s(w_sub[8*i +: 8]));
  end
  assign w_t  = w_sub ^ {i_rcon, 24'h000000};
  assign w_k0 = i_key[127:96] ^ w_t;
  assign w_k1 = i_key[95:64]  ^ w_k0;
  assign w_k2 = i_key[63:32]  ^ w_k1;
  assign w_k3 = i_key[31:0]   ^ w_k2;
  assign o_next_key = {w_k0, w_k1, w_k2, w_k3};
endmodule

module aes_enc_iter_umsk #(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);
  import aes_umsk_pkg::*;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;
  localparam logic [3:0] LAST_RND = 4'd10;

  fsm_e         r_fsm, w_fsm_nxt;
  logic [127:0] r_state, r_key, r_ct;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd_cnt;

  logic [127:0] w_round_state, w_round_key;
  logic [127:0] w_final_ark, w_final_sb, w_final_sr, w_final_ct;

  aes_round_umsk u_round (
    .i_state    (r_state),
    .i_key      (r_key),
    .i_rcon     (r_rcon),
    .o_state    (w_round_state),
    .o_next_key (w_round_key)
  );

  // Final round: SB + SR only; w_round_key carries round key 10 when rnd_cnt==10.
  assign w_final_ark = r_state ^ r_key;
  for (genvar i = 0; i < 16; i++) begin : g_fsb
    sbox_bp_umsk u_sb (.i_a(w_final_ark[8*i +: 8]), .o_s(w_final_sb[8*i +: 8]));
  end
  sr_umsk u_fsr (.i_s(w_final_sb), .o_s(w_final_sr));
  assign w_final_ct = w_final_sr ^ w_round_key;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = BUSY;
      end
      BUSY: begin
        if (r_rnd_cnt == LAST_RND)     w_fsm_nxt = DONE;
        else if (r_rnd_cnt > LAST_RND) w_fsm_nxt = IDLE;  // unreachable counts recover
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // NOTE: the wide datapath registers are reset too, so an aborted block can
  // never leave key material or a partial ciphertext visible after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= '0;
      r_key     <= '0;
      r_ct      <= '0;
      r_rcon    <= 8'h01;
      r_rnd_cnt <= 4'd0;
    end else begin
      case (r_fsm)
        IDLE: if (in_valid) begin
          r_state   <= pt_in;
          r_key     <= key_in;
          r_rcon    <= 8'h01;
          r_rnd_cnt <= 4'd1;
        end
        BUSY: begin
          if (r_rnd_cnt == LAST_RND) begin
            r_ct <= w_final_ct;
          end else if (r_rnd_cnt < LAST_RND) begin
            r_state   <= w_round_state;
            r_key     <= w_round_key;
            r_rcon    <= xtime(r_rcon);
            r_rnd_cnt <= r_rnd_cnt + 4'd1;
          end
        end
        DONE: if (out_ready && ZEROIZE) begin
          r_state <= '0;
          r_key   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ct_out = r_ct;

`ifdef AES_BLK_CNT_EN
  logic [31:0] r_blk_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_blk_cnt <= '0;
    else if (r_fsm == DONE && out_ready) r_blk_cnt <= r_blk_cnt + 32'd1;
  end
  assign blk_cnt = r_blk_cnt;
`endif
endmodule

// File: tb/tb_aes_enc_iter_umsk.sv
// Directed testbench for aes_enc_iter_umsk (FIPS-197 and SP800-38A vectors).
module tb_aes_enc_iter_umsk;
  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [127:0] pt_in, key_in;
  logic         in_ready, out_valid;
  logic [127:0] ct_out;
`ifdef AES_BLK_CNT_EN
  logic [31:0]  blk_cnt;
`endif

  aes_enc_iter_umsk dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_in     (pt_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct_out    (ct_out)
`ifdef AES_BLK_CNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0]   rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] v_key [4] = '{C1_KEY, B_KEY, 128'h0, B_KEY};
  logic [127:0] v_pt  [4] = '{C1_PT, B_PT, 128'h0, 128'h6bc1bee22e409f96e93d7e117393172a};
  logic [127:0] v_ct  [4] = '{C1_CT, B_CT, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                              128'h3ad77bb40d7a3660a89ecaf32466ef97};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offer a block, wait (bounded) for the accept edge, then scramble the inputs.
  task automatic accept(input logic [127:0] pt, input logic [127:0] key, input string name);
    int n;
    pt_in = pt; key_in = key; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept_timeout: in_ready=%b after %0d cycles, required 1", name, in_ready, n);
    end
    tick();
    in_valid = 1'b0; pt_in = ~pt; key_in = ~key;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
  endtask

  // Complete one block with out_ready high and check latency plus ciphertext.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input string name);
    int lat;
    out_ready = 1'b1;
    accept(pt, key, name);
    wait_out(lat);
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL %s latency: got %0d cycles, required 10", name, lat);
    end
    checks++;
    if (ct_out !== exp) begin
      errors++; $display("FAIL %s ct: got %h, required %h", name, ct_out, exp);
    end
    tick();  // output handshake
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt_in = '0; key_in = '0;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_hs: in_ready/out_valid=%b, required 10", {in_ready, out_valid});
    end
    checks++;
    if (ct_out !== 128'h0) begin
      errors++; $display("FAIL reset_ct: got %h, required 0", ct_out);
    end
    checks++;
    if (dut.r_rcon !== 8'h01 || dut.r_rnd_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_rcon_cnt: rcon=%h cnt=%0d, required 01 and 0", dut.r_rcon, dut.r_rnd_cnt);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_fips_c1();
    run_block(C1_PT, C1_KEY, C1_CT, "c1");
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL c1_idle: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
    end
  endtask

  task automatic test_app_b_rcon();
    out_ready = 1'b1;
    accept(B_PT, B_KEY, "appb");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dut.r_rcon !== rcon_exp[i] || dut.r_rnd_cnt !== 4'(i + 1)) begin
        errors++; $display("FAIL appb_rcon round %0d: rcon=%h cnt=%0d, required %h and %0d",
                           i + 1, dut.r_rcon, dut.r_rnd_cnt, rcon_exp[i], i + 1);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || ct_out !== B_CT) begin
      errors++; $display("FAIL appb_ct: out_valid=%b ct=%h, required 1 and %h", out_valid, ct_out, B_CT);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    accept(C1_PT, C1_KEY, "bp");
    wait_out(lat);
    checks++;
    if (lat !== 10 || ct_out !== C1_CT) begin
      errors++; $display("FAIL bp_first: lat=%0d ct=%h, required 10 and %h", lat, ct_out, C1_CT);
    end
    // A new block is offered throughout the stall; it must not be taken.
    in_valid = 1'b1; pt_in = B_PT; key_in = B_KEY;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ct_out !== C1_CT) begin
        errors++; $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b ct=%h, required 1, 0, %h",
                           i, out_valid, in_ready, ct_out, C1_CT);
      end
    end
    // in_valid and out_ready both high in DONE: handshake only, no accept.
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
    end
    checks++;
    if (dut.r_state !== 128'h0 || dut.r_key !== 128'h0) begin
      errors++; $display("FAIL bp_zeroize: state=%h key=%h, required 0", dut.r_state, dut.r_key);
    end
    checks++;
    if (ct_out !== C1_CT) begin
      errors++; $display("FAIL bp_ct_hold: got %h, required %h", ct_out, C1_CT);
    end
  endtask

  task automatic test_reset_mid_busy();
    out_ready = 1'b1;
    accept(C1_PT, C1_KEY, "rstmid");
    repeat (4) tick();
    checks++;
    if (dut.r_rnd_cnt !== 4'd5) begin
      errors++; $display("FAIL rstmid_round: cnt=%0d, required 5", dut.r_rnd_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ct_out !== 128'h0) begin
      errors++; $display("FAIL rstmid_abort: out_valid=%b in_ready=%b ct=%h, required 0, 1, 0",
                         out_valid, in_ready, ct_out);
    end
    #2 rst = 1'b0;
    run_block(C1_PT, C1_KEY, C1_CT, "rstmid_c1");
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int lat, n;
    out_ready = 1'b1;
    in_valid = 1'b1; pt_in = v_pt[0]; key_in = v_key[0];
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (!in_ready && n < 40) begin tick(); n++; end
      tick();  // accept edge
      acc[b] = cyc;
      if (b < 3) begin pt_in = v_pt[b + 1]; key_in = v_key[b + 1]; end
      else       begin pt_in = ~pt_in; end
      wait_out(lat);
      checks++;
      if (lat !== 10 || ct_out !== v_ct[b]) begin
        errors++; $display("FAIL b2b_ct block %0d: lat=%0d ct=%h, required 10 and %h", b, lat, ct_out, v_ct[b]);
      end
      // 10 rounds + one DONE cycle + one IDLE cycle between accept edges.
      if (b > 0) begin
        checks++;
        if (acc[b] - acc[b - 1] !== 12) begin
          errors++; $display("FAIL b2b_spacing block %0d: %0d cycles, required 12", b, acc[b] - acc[b - 1]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef AES_BLK_CNT_EN
  task automatic test_blk_cnt();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) run_block(v_pt[i], v_key[i], v_ct[i], "cnt");
    checks++;
    if (blk_cnt !== 32'd3) begin
      errors++; $display("FAIL blk_cnt_three: got %0d, required 3", blk_cnt);
    end
    force dut.r_blk_cnt = 32'hffffffff;
    #1 release dut.r_blk_cnt;
    run_block(C1_PT, C1_KEY, C1_CT, "cnt_wrap");
    checks++;
    if (blk_cnt !== 32'd0) begin
      errors++; $display("FAIL blk_cnt_wrap: got %h, required 00000000", blk_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fips_c1();
    test_app_b_rcon();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef AES_BLK_CNT_EN
    test_blk_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
